// File: rtl/baud_pkg.sv
// Shared constants and constant functions for the multi-rate baud generator.
// BAUD_GEN_FRAC_EN (defined in the top) selects the fractional engine.
package baud_pkg;

    localparam int unsigned CLK_FREQ_DEF = 100_000_000;

    localparam logic [1:0] SEL_B0 = 2'd0;
    localparam logic [1:0] SEL_B1 = 2'd1;
    localparam logic [1:0] SEL_B2 = 2'd2;
    localparam logic [1:0] SEL_B3 = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // round(clk / (baud * os))
    function automatic int unsigned calc_div(int unsigned clk_freq, int unsigned baud,
                                             int unsigned os);
        longint unsigned bo;
        bo = 64'(baud) * 64'(os);
        return 32'((64'(clk_freq) + bo / 2) / bo);
    endfunction

    // round(baud * os * 2^acc_w / clk)
    function automatic longint unsigned calc_inc(int unsigned clk_freq, int unsigned baud,
                                                 int unsigned os, int unsigned acc_w);
        longint unsigned bo;
        bo = 64'(baud) * 64'(os);
        return ((bo << acc_w) + 64'(clk_freq) / 2) / 64'(clk_freq);
    endfunction

    function automatic int unsigned max4(int unsigned a, int unsigned b,
                                         int unsigned c, int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/baud_os_counter.sv
// Oversample position counter: turns the os strobe into mid-bit and bit ticks.
module baud_os_counter
    import baud_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    input  logic os_tick_i,
    output logic mid_tick_o,
    output logic baud_tick_o
);

    localparam int unsigned     OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic            adv, mid_d, baud_d, mid_q, baud_q;

    assign adv = os_tick_i & en_i & ~restart_i;

    always_comb begin
        os_cnt_d = os_cnt_q;
        mid_d    = adv && (os_cnt_q == MID);
        baud_d   = adv && (os_cnt_q == LAST);
        if (restart_i) begin
            os_cnt_d = '0;
        end else if (adv) begin
            os_cnt_d = (os_cnt_q == LAST) ? '0 : os_cnt_q + OS_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            os_cnt_q <= '0;
            mid_q    <= 1'b0;
            baud_q   <= 1'b0;
        end else begin
            os_cnt_q <= os_cnt_d;
            mid_q    <= mid_d;
            baud_q   <= baud_d;
        end
    end

    assign mid_tick_o  = mid_q;
    assign baud_tick_o = baud_q;

endmodule

// File: rtl/baud_gen_multi.sv
// Runtime-selectable oversampling baud generator with restart and enable.
// Define BAUD_GEN_FRAC_EN for the phase-accumulator engine; default is integer DIV.
module baud_gen_multi
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
    parameter int unsigned BAUD0      = 9600,
    parameter int unsigned BAUD1      = 19200,
    parameter int unsigned BAUD2      = 57600,
    parameter int unsigned BAUD3      = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    input  logic [1:0] baud_sel,
    output logic       os_tick,
    output logic       mid_tick,
    output logic       baud_tick
);

    if (OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("OVERSAMPLE must be even and within 4..32");
    end
    if (ACC_W < 8 || ACC_W > 40) begin : g_bad_acc
        $error("ACC_W must be within 8..40");
    end

    logic [1:0] sel_q;
    logic       clr, run, os_pulse, os_tick_q;
    state_t     state;

    assign state = en ? ST_RUN : ST_IDLE;
    assign run   = (state == ST_RUN);
    // A new rate realigns everything exactly like an explicit restart.
    assign clr   = restart | (baud_sel != sel_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q     <= SEL_B0;
            os_tick_q <= 1'b0;
        end else begin
            sel_q     <= baud_sel;
            os_tick_q <= os_pulse;
        end
    end

`ifdef BAUD_GEN_FRAC_EN
    localparam logic [ACC_W-1:0] INC0 = ACC_W'(calc_inc(CLK_FREQ, BAUD0, OVERSAMPLE, ACC_W));
    localparam logic [ACC_W-1:0] INC1 = ACC_W'(calc_inc(CLK_FREQ, BAUD1, OVERSAMPLE, ACC_W));
    localparam logic [ACC_W-1:0] INC2 = ACC_W'(calc_inc(CLK_FREQ, BAUD2, OVERSAMPLE, ACC_W));
    localparam logic [ACC_W-1:0] INC3 = ACC_W'(calc_inc(CLK_FREQ, BAUD3, OVERSAMPLE, ACC_W));

    logic [ACC_W-1:0] inc, acc_q, acc_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        inc = INC0;
        case (sel_q)
            SEL_B1:  inc = INC1;
            SEL_B2:  inc = INC2;
            SEL_B3:  inc = INC3;
            default: ;
        endcase
    end

    assign sum = {1'b0, acc_q} + {1'b0, inc};

    // The carry out of the accumulator is the oversample strobe.
    always_comb begin
        acc_d    = acc_q;
        os_pulse = 1'b0;
        if (clr) begin
            acc_d = '0;
        end else if (run) begin
            acc_d    = sum[ACC_W-1:0];
            os_pulse = sum[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end
`else
    localparam int unsigned DIV0    = calc_div(CLK_FREQ, BAUD0, OVERSAMPLE);
    localparam int unsigned DIV1    = calc_div(CLK_FREQ, BAUD1, OVERSAMPLE);
    localparam int unsigned DIV2    = calc_div(CLK_FREQ, BAUD2, OVERSAMPLE);
    localparam int unsigned DIV3    = calc_div(CLK_FREQ, BAUD3, OVERSAMPLE);
    localparam int unsigned DIV_MAX = max4(DIV0, DIV1, DIV2, DIV3);
    localparam int unsigned CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    logic [CNT_W-1:0] div_m1, cnt_q, cnt_d;

    always_comb begin
        div_m1 = CNT_W'(DIV0 - 1);
        case (sel_q)
            SEL_B1:  div_m1 = CNT_W'(DIV1 - 1);
            SEL_B2:  div_m1 = CNT_W'(DIV2 - 1);
            SEL_B3:  div_m1 = CNT_W'(DIV3 - 1);
            default: ;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        os_pulse = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q >= div_m1) begin
                cnt_d    = '0;
                os_pulse = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif

    baud_os_counter #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_os_counter (
        .clk_i      (clk),
        .rst_ni     (rst),
        .en_i       (run),
        .restart_i  (clr),
        .os_tick_i  (os_pulse),
        .mid_tick_o (mid_tick),
        .baud_tick_o(baud_tick)
    );

    assign os_tick = os_tick_q;

endmodule

// File: tb/tb_baud_gen_multi.sv
// Directed, scoreboard-driven bench for baud_gen_multi (both engine builds).
module tb_baud_gen_multi;

    logic       clk = 1'b0;
    logic       rst, en, restart;
    logic [1:0] baud_sel;
    logic       os_tick, mid_tick, baud_tick;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string  tag;
        longint val;
    } exp_t;
    exp_t sbq[$];

    baud_gen_multi dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .restart  (restart),
        .baud_sel (baud_sel),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .baud_tick(baud_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input longint v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic check(input longint obs);
        exp_t e;
        compared++;
        if (sbq.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty: observed %0d, no expected entry", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val)
            else begin
                mismatched++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return os_tick;
            1:       return mid_tick;
            default: return baud_tick;
        endcase
    endfunction

    // Edges until the selected output is seen high; -1 if the budget runs out.
    task automatic wait_for(input int which, input int budget, output longint n);
        logic hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < budget) begin
            step();
            n++;
            hit = sig_of(which);
        end
        if (!hit) n = -1;
    endtask

    task automatic count_ticks(input int edges, output int c);
        c = 0;
        for (int i = 0; i < edges; i++) begin
            step();
            if (os_tick || mid_tick || baud_tick) c++;
        end
    endtask

    function automatic longint outs();
        return longint'({os_tick, mid_tick, baud_tick});
    endfunction

    initial begin
        longint n;
        int     c;
        rst      = 1'b0;
        en       = 1'b0;
        restart  = 1'b0;
        baud_sel = 2'd0;
        #100;
        push_exp("reset_os", 0);   check(longint'(os_tick));
        push_exp("reset_mid", 0);  check(longint'(mid_tick));
        push_exp("reset_baud", 0); check(longint'(baud_tick));
        en  = 1'b1;
        rst = 1'b1;

`ifndef BAUD_GEN_FRAC_EN
        push_exp("first_os", 651);       wait_for(0, 20000, n); check(n);
        push_exp("os_to_mid", 7 * 651);  wait_for(1, 20000, n); check(n);
        push_exp("mid_with_os", 1);      check(longint'(os_tick));
        push_exp("mid_not_baud", 0);     check(longint'(baud_tick));
        push_exp("mid_to_baud", 8 * 651); wait_for(2, 20000, n); check(n);
        push_exp("baud_not_mid", 0);     check(longint'(mid_tick));
        push_exp("baud_period", 10416);  wait_for(2, 20000, n); check(n);

        // Stall mid-period and confirm the interrupted period completes.
        count_ticks(300, c);
        en = 1'b0;
        count_ticks(500, c);
        push_exp("en_low_ticks", 0);     check(longint'(c));
        en = 1'b1;
        push_exp("resume_os", 351);      wait_for(0, 20000, n); check(n);
        push_exp("resume_baud", 15 * 651); wait_for(2, 20000, n); check(n);

        // Restart lands exactly on the edge where a baud_tick is due.
        repeat (10415) step();
        restart = 1'b1;
        step();
        push_exp("restart_outputs", 0);  check(outs());
        restart = 1'b0;
        push_exp("restart_os", 651);     wait_for(0, 20000, n); check(n);
        push_exp("restart_baud", 15 * 651); wait_for(2, 20000, n); check(n);

        // Rate change with os_cnt part-way through a bit.
        repeat (3000) step();
        baud_sel = 2'd1;
        step();
        push_exp("sel_change_outputs", 0); check(outs());
        push_exp("sel1_os", 326);        wait_for(0, 20000, n); check(n);
        push_exp("sel1_period", 326);    wait_for(0, 20000, n); check(n);
        push_exp("sel1_baud", 14 * 326); wait_for(2, 20000, n); check(n);

        baud_sel = 2'd2;
        step();
        push_exp("sel2_os", 109);        wait_for(0, 20000, n); check(n);
        baud_sel = 2'd3;
        step();
        push_exp("sel3_os", 54);         wait_for(0, 20000, n); check(n);
        push_exp("sel3_period", 54);     wait_for(0, 20000, n); check(n);
`else
        begin
            longint inc0, inc3, two32, total, first;
            int     bad, mids, bauds;
            two32 = 64'd1 << 32;
            inc0  = 6_597_070;
            inc3  = 79_164_837;
            push_exp("frac_first_os", (two32 + inc0 - 1) / inc0);
            wait_for(0, 20000, n); check(n);

            baud_sel = 2'd3;
            step();
            push_exp("sel_change_outputs", 0); check(outs());
            total = 0; first = 0; bad = 0; mids = 0; bauds = 0;
            for (int i = 0; i < 1000; i++) begin
                wait_for(0, 200, n);
                if (i == 0) first = n;
                if (n < 54 || n > 55) bad++;
                total += n;
                if (mid_tick)  mids++;
                if (baud_tick) bauds++;
            end
            push_exp("frac_sel3_first", (two32 + inc3 - 1) / inc3); check(first);
            push_exp("frac_period_out_of_range", 0); check(longint'(bad));
            $display("info: 1000 os periods took %0d clk", total);
            push_exp("frac_total_within_1", 1);
            check(longint'((total >= (1000 * two32 + inc3 - 1) / inc3 - 1) &&
                           (total <= (1000 * two32 + inc3 - 1) / inc3 + 1)));
            push_exp("frac_mid_count", 63);  check(longint'(mids));
            push_exp("frac_baud_count", 62); check(longint'(bauds));

            restart = 1'b1;
            step();
            push_exp("restart_outputs", 0); check(outs());
            restart = 1'b0;
            push_exp("frac_restart_os", (two32 + inc3 - 1) / inc3);
            wait_for(0, 20000, n); check(n);
        end
`endif

        // os_tick is high right now; an async reset must clear it before the next edge.
        rst = 1'b0;
        #2;
        push_exp("async_reset_outputs", 0); check(outs());
        baud_sel = 2'd0;
        #20;
        rst = 1'b1;
`ifndef BAUD_GEN_FRAC_EN
        push_exp("post_reset_os", 651);
`else
        push_exp("post_reset_os", ((64'd1 << 32) + 6_597_070 - 1) / 6_597_070);
`endif
        wait_for(0, 20000, n); check(n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/baud_gen_multi.md
# baud_gen_multi

Runtime-selectable, oversampling baud-rate generator replacing the single-rate fixed-divider generator in the UART path. It produces a 1-cycle oversample tick for the UART receiver, a mid-bit sample tick, and a 1-cycle bit tick for the transmitter. It supports four selectable rates, an enable, and a synchronous restart for start-bit alignment. A phase-accumulator (fractional) mode removes divider rounding error.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz
- BAUD0 / BAUD1 / BAUD2 / BAUD3, 9600 / 19200 / 57600 / 115200: rates selected by baud_sel = 0..3
- OVERSAMPLE, 16: oversample ticks per bit; even, 4..32
- ACC_W, 32: phase-accumulator width (fractional mode only)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  run enable
- restart  in  1  synchronous re-alignment pulse
- baud_sel  in  2  rate select
- os_tick  out  1  oversample tick, 1-cycle pulse
- mid_tick  out  1  mid-bit sample pulse
- baud_tick  out  1  bit-period pulse

## Operation
- **Rate engine, integer mode:**
  - DIV = round(CLK_FREQ / (BAUDn·OVERSAMPLE)).
  - Counter runs 0..DIV-1 and wraps to 0.
  - os_tick fires on the wrap.
- **Rate engine, fractional mode:**
  - INC = round(BAUDn·OVERSAMPLE·2^ACC_W / CLK_FREQ).
  - acc <= acc + INC, computed modulo 2^ACC_W.
  - os_tick fires on carry-out.
- **Oversample counter (os_cnt):**
  - Counts 0..OVERSAMPLE-1 on each os_tick and wraps.
  - mid_tick = os_tick while os_cnt == OVERSAMPLE/2-1.
  - baud_tick = os_tick while os_cnt == OVERSAMPLE-1.
- **Registers:** baud_sel is registered every cycle. A change of the registered value acts as restart.
- **restart:**
  - Clears the rate counter/acc and os_cnt.
  - Outputs are 0 in that cycle.
  - restart has priority over en and over a coincident tick; that tick is dropped.
- **en low:**
  - All state holds.
  - All outputs are 0.
  - Counting resumes from the held state when en returns high.
- **States:** IDLE (en=0) and RUN (en=1). restart returns the counters to zero without a state change.

## Timing
- **Reset:**
  - All outputs are 0.
  - Counter, acc and os_cnt are 0.
  - Registered baud_sel is 0.
- **Registered outputs:** all outputs are registered and assert for exactly one clk.
- **Integer mode, first os_tick:** occurs DIV rising edges after the first edge with en=1 (following reset release or restart).
- **Fractional mode, first os_tick:** occurs ceil(2^ACC_W / INC) edges after that same first edge.
- **Coincident ticks:** baud_tick and mid_tick coincide with an os_tick, never with each other. baud_tick period is OVERSAMPLE os_ticks.
- **Worked values at 100 MHz, ×16:**
  - 9600: DIV = 651, INC = 6_597_070, baud period = 10_416 clk (integer mode).
  - 115200: DIV = 54, INC = 79_164_837.
- **baud_sel change:** the new rate applies one edge after the change, and the restart semantics apply.

## Configuration
- The macro BAUD_GEN_FRAC_EN selects the rate engine.
- **Defined:** fractional phase-accumulator engine. Long-run mean os_tick period is within 1 clk/10^6 of ideal; instantaneous period dithers between floor and ceil of the ideal period.
- **Undefined:** integer DIV counter. Period is fixed at DIV. Error is the rounding of DIV, e.g. -0.47 % at 115200. ACC_W is unused.

## Structure
- **Shared package baud_pkg holds:**
  - CLK_FREQ default.
  - The baud_sel encoding constants.
  - Constant functions calc_div() and calc_inc().
- **Sub-module baud_os_counter:**
  - Inputs: os_tick, restart, en.
  - Produces os_cnt, mid_tick and baud_tick.
  - The rate engine stays in the top level.

## Test plan
- Reset held 100 ns, then en=1, baud_sel=0, integer mode → first os_tick 651 clk after release; baud_tick every 10_416 clk; mid_tick exactly 8·651 clk before each baud_tick.
- Fractional mode, baud_sel=3, run 10_000 os_ticks → total elapsed clk = 542_535 ±1; every individual period is 54 or 55.
- en dropped for 500 clk mid-bit → no ticks while low; the next os_tick completes the interrupted period with no lost or extra count.
- restart pulsed in the same cycle a baud_tick is due → no baud_tick; next os_tick after a full DIV; next baud_tick after OVERSAMPLE os_ticks.
- baud_sel 0→1 mid-operation → counters clear; os_tick period becomes 326 clk (integer mode).
- rst asserted asynchronously mid-period → all outputs 0 immediately, before the next clk edge.
